// File: rtl/shared_slow_memory.sv
// shared_slow_memory: NCH requesters share one slow line memory through a round-robin arbiter.
// Purpose : one transaction in flight; grant in IDLE, ready pulse LATENCY cycles after the grant,
//           then a one-cycle GAP before the next grant.
// Ports   : clk, rst (async, active high)
//           mem_read/mem_write [NCH]    per-channel requests (write wins when both are set)
//           mem_addr  [NCH*ADDR_W]      per-channel line address (only low DEPTH_LOG2 bits used)
//           mem_wdata [NCH*LINE_W]      per-channel write line
//           mem_rdata [NCH*LINE_W]      per-channel registered read line, held until next read
//           mem_ready [NCH]             one-cycle completion pulse
//           rd_cnt, wr_cnt, stall_cnt   statistics, live only when SLOWMEM_STATS_EN is defined
module shared_slow_memory #(
    parameter int NCH        = 2,
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = 28,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           mem_read,
    input  logic [NCH-1:0]           mem_write,
    input  logic [NCH*ADDR_W-1:0]    mem_addr,
    input  logic [NCH*LINE_W-1:0]    mem_wdata,
    output logic [NCH*LINE_W-1:0]    mem_rdata,
    output logic [NCH-1:0]           mem_ready,
    output logic [31:0]              rd_cnt,
    output logic [31:0]              wr_cnt,
    output logic [31:0]              stall_cnt
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          gnt_q, gnt_d, rr_q, rr_d, k;
    logic [7:0]             cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0]      wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic [NCH*LINE_W-1:0]  rdata_q;
    logic [LINE_W-1:0]      mem [0:(1<<DEPTH_LOG2)-1];
    logic [NCH-1:0]         req;
    logic                   found, stall;
    logic                   addr_unused;

    assign req         = mem_read | mem_write;
    assign mem_rdata   = rdata_q;
    // upper address bits alias onto the array and are intentionally dropped
    assign addr_unused = ^mem_addr;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        found   = 1'b0;
        k       = '0;
        case (state_q)
            IDLE: begin
                // first requester at or after the round-robin pointer wins
                for (int i = 0; i < NCH; i++) begin
                    k = CW'((int'(rr_q) + i) % NCH);
                    if (!found && req[k]) begin
                        found   = 1'b1;
                        gnt_d   = k;
                        wr_d    = mem_write[k];
                        idx_d   = mem_addr[k*ADDR_W +: DEPTH_LOG2];
                        wdata_d = mem_wdata[k*LINE_W +: LINE_W];
                        cnt_d   = 8'(LATENCY - 1);
                        state_d = (LATENCY == 1) ? RESP : BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == 8'd1) ? RESP : BUSY;
            end
            RESP: state_d = GAP;
            GAP: begin
                rr_d    = (int'(gnt_q) == NCH - 1) ? '0 : gnt_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // in IDLE the channel being granted this cycle is not counted as stalled
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            mem_ready[i] = (state_q == RESP) && (int'(gnt_q) == i);
            stall = stall | (req[i] && int'((state_q == IDLE) ? gnt_d : gnt_q) != i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            // read data is captured on entry to RESP so it is valid alongside mem_ready
            if (state_d == RESP && !wr_d)
                rdata_q[gnt_d*LINE_W +: LINE_W] <= mem[idx_d];
        end
    end

    // array is never reset; a write lands only at the end of RESP, so a reset before then drops it
    always_ff @(posedge clk) begin
        if (state_q == RESP && wr_q)
            mem[idx_q] <= wdata_q;
    end

`ifdef SLOWMEM_STATS_EN
    logic [31:0] rd_q, wrc_q, stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wrc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (state_q == RESP && !wr_q && rd_q != '1)
                rd_q <= rd_q + 1'b1;
            if (state_q == RESP && wr_q && wrc_q != '1)
                wrc_q <= wrc_q + 1'b1;
            if (stall && stall_q != '1)
                stall_q <= stall_q + 1'b1;
        end
    end

    assign rd_cnt    = rd_q;
    assign wr_cnt    = wrc_q;
    assign stall_cnt = stall_q;
`else
    assign rd_cnt    = '0;
    assign wr_cnt    = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_shared_slow_memory.sv
// tb_shared_slow_memory: directed and randomized checks of shared_slow_memory against a timestamp model.
module tb_shared_slow_memory;
    localparam int NCH = 2;
    localparam int LW  = 128;
    localparam int AW  = 28;
    localparam int LAT = 8;
`ifdef SLOWMEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        rd = '0, wr = '0;
    logic [2*AW-1:0]   addr = '0;
    logic [2*LW-1:0]   wdata = '0;
    logic [2*LW-1:0]   rdata;
    logic [1:0]        ready;
    logic [31:0]       rd_cnt, wr_cnt, stall_cnt;

    logic [1:0]        f_rd = '0, f_wr = '0;
    logic [2*AW-1:0]   f_addr = '0;
    logic [2*LW-1:0]   f_wdata = '0;
    logic [2*LW-1:0]   f_rdata;
    logic [1:0]        f_ready;
    logic [31:0]       f_rc, f_wc, f_sc;

    always #5 clk = ~clk;

    shared_slow_memory #(.NCH(NCH), .LINE_W(LW), .ADDR_W(AW), .DEPTH_LOG2(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .mem_addr(addr), .mem_wdata(wdata),
        .mem_rdata(rdata), .mem_ready(ready), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .stall_cnt(stall_cnt)
    );

    shared_slow_memory #(.NCH(NCH), .LINE_W(LW), .ADDR_W(AW), .DEPTH_LOG2(10), .LATENCY(1)) u_fast (
        .clk(clk), .rst(rst), .mem_read(f_rd), .mem_write(f_wr), .mem_addr(f_addr), .mem_wdata(f_wdata),
        .mem_rdata(f_rdata), .mem_ready(f_ready), .rd_cnt(f_rc), .wr_cnt(f_wc), .stall_cnt(f_sc)
    );

    int          n_tests = 0, n_fail = 0, cyc = 0;
    logic [LW-1:0] mem_m [0:1023];
    logic [LW-1:0] exp_rd [0:1] = '{'0, '0};
    int          rr_m = 0, free_at = 0, g_cyc = -100, done = -100, m_ch = 0, m_idx = 0;
    logic        m_wr = 1'b0;
    logic [LW-1:0] m_wd = '0;
    logic [31:0] e_rd = '0, e_wr = '0, e_st = '0;
    logic [1:0]  obs_ready = '0, m_ready = '0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int ch, input logic r, input logic w, input logic [AW-1:0] a,
                           input logic [LW-1:0] d);
        rd[ch] = r;
        wr[ch] = w;
        addr[ch*AW +: AW] = a;
        wdata[ch*LW +: LW] = d;
    endtask

    // one clock cycle: sample at negedge, advance the model, compare, return #1 after posedge
    task automatic cycle();
        logic st;
        @(negedge clk);
        obs_ready = ready;
        if (cyc >= free_at) begin
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (rr_m + i) % NCH;
                if (rd[c] | wr[c]) begin
                    m_ch = c;
                    m_wr = wr[c];
                    m_idx = int'(addr[c*AW +: 10]);
                    m_wd = wdata[c*LW +: LW];
                    g_cyc = cyc;
                    done = cyc + LAT;
                    free_at = done + 2;
                    rr_m = (c + 1) % NCH;
                    break;
                end
            end
        end
        st = 1'b0;
        if (cyc >= g_cyc && cyc <= done + 1)
            for (int i = 0; i < NCH; i++)
                if (i != m_ch && (rd[i] | wr[i])) st = 1'b1;
        m_ready = (cyc == done) ? 2'(1 << m_ch) : 2'b00;
        if (cyc == done) begin
            if (m_wr) mem_m[m_idx] = m_wd;
            else exp_rd[m_ch] = mem_m[m_idx];
        end
        chk("ready", LW'(ready), LW'(m_ready));
        chk("rdata0", rdata[0 +: LW], exp_rd[0]);
        chk("rdata1", rdata[LW +: LW], exp_rd[1]);
        chk("rd_cnt", LW'(rd_cnt), STATS ? LW'(e_rd) : '0);
        chk("wr_cnt", LW'(wr_cnt), STATS ? LW'(e_wr) : '0);
        chk("stall_cnt", LW'(stall_cnt), STATS ? LW'(e_st) : '0);
        if (cyc == done) begin
            if (m_wr) e_wr++;
            else e_rd++;
        end
        if (st) e_st++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ready", LW'(ready), '0);
        chk("rst_rdata0", rdata[0 +: LW], '0);
        chk("rst_rdata1", rdata[LW +: LW], '0);
        chk("rst_cnts", LW'(rd_cnt | wr_cnt | stall_cnt), '0);
        rr_m = 0;
        free_at = 0;
        g_cyc = -100;
        done = -100;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        e_rd = '0;
        e_wr = '0;
        e_st = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int ch, output int at, output int who);
        at = -1;
        who = -1;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (ch < 0 ? |obs_ready : obs_ready[ch]) begin
                at = cyc - 1;
                who = obs_ready[1] ? 1 : 0;
                break;
            end
        end
        chk("wait_timeout", LW'(at < 0), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, at, who;
        logic [1:0] act;
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b0, 1'b1, AW'(i), (i == 5) ? LW'('hA5) : LW'('hC0 + i));
            wait_ready(0, at, who);
            set_req(0, 1'b0, 1'b0, '0, '0);
        end
        cycle();

        set_req(0, 1'b1, 1'b0, AW'(5), '0);
        s = cyc;
        wait_ready(0, at, who);
        chk("single_read_lat", LW'(at - s), LW'(8));
        chk("single_read_data", rdata[0 +: LW], LW'('hA5));
        set_req(0, 1'b0, 1'b0, '0, '0);
        repeat (3) cycle();
        chk("single_read_hold", rdata[0 +: LW], LW'('hA5));

        set_req(0, 1'b0, 1'b1, AW'(3), LW'('h1234));
        wait_ready(0, at, who);
        set_req(0, 1'b0, 1'b0, '0, '0);
        cycle();
        set_req(0, 1'b1, 1'b0, AW'(3), '0);
        s = cyc;
        wait_ready(0, at, who);
        chk("wr_rd_lat", LW'(at - s), LW'(8));
        chk("wr_rd_data", rdata[0 +: LW], LW'('h1234));
        set_req(0, 1'b0, 1'b0, '0, '0);
        cycle();

        set_req(1, 1'b0, 1'b1, AW'(7), LW'('hFF));
        repeat (4) cycle();
        set_req(1, 1'b0, 1'b0, '0, '0);
        do_reset();

        set_req(0, 1'b1, 1'b0, AW'(1), '0);
        set_req(1, 1'b1, 1'b0, AW'(2), '0);
        s = cyc;
        wait_ready(0, at, who);
        chk("contend_ch0_lat", LW'(at - s), LW'(8));
        set_req(0, 1'b0, 1'b0, '0, '0);
        wait_ready(1, at, who);
        chk("contend_ch1_lat", LW'(at - s), LW'(18));
        chk("contend_stall", LW'(STATS ? (stall_cnt >= 9) : (stall_cnt == 0)), LW'(1));
        set_req(1, 1'b0, 1'b0, '0, '0);
        cycle();

        set_req(0, 1'b1, 1'b0, AW'(7), '0);
        wait_ready(0, at, who);
        chk("rst_write_dropped", rdata[0 +: LW], LW'('hC7));

        set_req(0, 1'b1, 1'b0, AW'(1), '0);
        set_req(1, 1'b1, 1'b0, AW'(2), '0);
        for (int j = 0; j < 4; j++) begin
            wait_ready(-1, at, who);
            chk("fair_order", LW'(who), LW'((j % 2 == 0) ? 1 : 0));
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) cycle();

        act = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (m_ready[ch]) begin
                    act[ch] = 1'b0;
                    set_req(ch, 1'b0, 1'b0, '0, '0);
                end else if (act[ch]) begin
                    int r;
                    r = $urandom_range(0, 15);
                    if (r == 0) begin
                        act[ch] = 1'b0;
                        set_req(ch, 1'b0, 1'b0, '0, '0);
                    end else if (r < 3) begin
                        addr[ch*AW +: AW] = AW'(($urandom & 32'hFFFF_FC00) | $urandom_range(0, 7));
                        wdata[ch*LW +: LW] = {$urandom, $urandom, $urandom, $urandom};
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    int op;
                    op = $urandom_range(0, 2);
                    act[ch] = 1'b1;
                    set_req(ch, op != 1, op != 0, AW'(($urandom & 32'hFFFF_FC00) | $urandom_range(0, 7)),
                            {$urandom, $urandom, $urandom, $urandom});
                end
            end
            cycle();
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (12) cycle();

        f_wr[1] = 1'b1;
        f_addr[AW +: AW] = AW'(5);
        f_wdata[LW +: LW] = LW'('h5A);
        @(negedge clk);
        chk("fast_wr_c0", LW'(f_ready), '0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fast_wr_c1", LW'(f_ready), LW'(2'b10));
        @(posedge clk);
        #1;
        f_wr[1] = 1'b0;
        @(posedge clk);
        #1;
        f_rd[0] = 1'b1;
        f_addr[0 +: AW] = AW'(1029);
        @(negedge clk);
        chk("fast_rd_c0", LW'(f_ready), '0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fast_rd_c1", LW'(f_ready), LW'(2'b01));
        chk("fast_alias_data", f_rdata[0 +: LW], LW'('h5A));
        @(posedge clk);
        #1;
        f_rd[0] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
